dp_encoder: RTL

DP_ENCODER -- requirements
Module: dp_encoder

---
 rtl/dp_encoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dp_encoder.sv
// Data-processing instruction encoder: registers the fields on accept, searches
// for a rotated 8-bit immediate when needed, and hands out one 32-bit word.
module dp_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cond,
  input  logic [3:0]  opcode,
  input  logic        s_bit,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [1:0]  op_kind,
  input  logic [31:0] imm_value,
  input  logic [3:0]  rm,
  input  logic [3:0]  rs,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_amt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        out_error,
  output logic [7:0]  out_addr
);

  // state  | meaning
  // IDLE   | waiting for a field request, in_ready high
  // SEARCH | trying one rotation of the immediate per cycle
  // OUT    | result presented, held until out_ready
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_OUT    = 2'd2
  } state_t;

  localparam logic [1:0] K_IMM   = 2'b00;
  localparam logic [1:0] K_RSIMM = 2'b01;
  localparam logic [1:0] K_RSREG = 2'b10;

  state_t      state_q, state_d;
  logic [3:0]  rot_q, rot_d;
  logic [19:0] hdr_q, hdr_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [7:0]  addr_q, addr_d;

  logic        accept;
  logic        s_eff;
  logic [3:0]  rn_eff;
  logic        i_bit;
  logic [19:0] hdr_in;
  logic [4:0]  rot_sh;
  logic [31:0] cand;

  assign in_ready  = (state_q == S_IDLE) & rst_n;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_OUT);
  assign instr     = instr_q;
  assign out_error = err_q;
  assign out_addr  = addr_q;

  // Compares always set flags; moves have no first operand.
  assign s_eff  = s_bit | (opcode[3:2] == 2'b10);
  assign rn_eff = ((opcode == 4'b1101) || (opcode == 4'b1111)) ? 4'b0000 : rn;
  assign i_bit  = (op_kind == K_IMM);
  assign hdr_in = {cond, 2'b00, i_bit, opcode, s_eff, rn_eff, rd};

  // Left-rotating by 2*rot undoes the ROR the core applies when decoding.
  assign rot_sh = {rot_q, 1'b0};
  assign cand   = (imm_q << rot_sh) | (imm_q >> (6'd32 - {1'b0, rot_sh}));

  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    hdr_d   = hdr_q;
    imm_d   = imm_q;
    instr_d = instr_q;
    err_d   = err_q;
    addr_d  = addr_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hdr_d = hdr_in;
          imm_d = imm_value;
          rot_d = 4'd0;
          case (op_kind)
            K_IMM: begin
              err_d   = 1'b0;
              state_d = S_SEARCH;
            end
            K_RSIMM: begin
              instr_d = {hdr_in, shift_amt, shift_type, 1'b0, rm};
              err_d   = 1'b0;
              state_d = S_OUT;
            end
            K_RSREG: begin
              instr_d = {hdr_in, rs, 1'b0, shift_type, 1'b1, rm};
              err_d   = 1'b0;
              state_d = S_OUT;
            end
            default: begin
              instr_d = 32'h0;
              err_d   = 1'b1;
              state_d = S_OUT;
            end
          endcase
        end
      end

      S_SEARCH: begin
        if (cand[31:8] == 24'h0) begin
          instr_d = {hdr_q, rot_q, cand[7:0]};
          err_d   = 1'b0;
          state_d = S_OUT;
        end else if (rot_q == 4'd15) begin
          instr_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          rot_d = rot_q + 4'd1;
        end
      end

      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          if (!err_q) addr_d = addr_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rot_q   <= 4'd0;
      hdr_q   <= 20'h0;
      imm_q   <= 32'h0;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
      addr_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      hdr_q   <= hdr_d;
      imm_q   <= imm_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

endmodule
